// File: rtl/subleq_pkg.sv
// Shared definitions for the SUBLEQ MMIO FIFO bridge: width and MMIO
// address defaults, plus the CPU-side access FSM state encoding.
package subleq_pkg;

    localparam int WORD_SIZE_DEF = 16;

    // Wide all-ones constant; the top slices it down to its own WORD_SIZE
    // so the default MMIO address tracks the configured width.
    localparam logic [63:0] IO_ADDR_DEF = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM,
        S_IORD,
        S_IOWR,
        S_RESP
    } cpu_state_t;

endpackage

// File: rtl/subleq_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count.
// A push while full or a pop while empty is ignored, so the FIFO cannot
// overflow or underflow. It has no bypass: a word pushed in one cycle
// can first be popped in the next cycle.
module subleq_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    // Head reads as zero when the FIFO is empty, so data outputs are clean after reset.
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage write; the contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally at the power-of-two depth; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/subleq_mmio_fifo.sv
// MMIO bridge between a SUBLEQ CPU and memory. Accesses to IO_ADDR read
// from a prefetching input FIFO or write to a draining output FIFO. All
// other addresses are forwarded to memory.
module subleq_mmio_fifo
    import subleq_pkg::*;
#(
    parameter int                   WORD_SIZE = WORD_SIZE_DEF,
    parameter int                   IN_DEPTH  = 4,
    parameter int                   OUT_DEPTH = 4,
    parameter logic [WORD_SIZE-1:0] IO_ADDR   = IO_ADDR_DEF[WORD_SIZE-1:0]
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 in_eof,
    input  logic                 in_ack,
    output logic                 in_req,
    input  logic [WORD_SIZE-1:0] in_data,
    input  logic                 out_ack,
    output logic                 out_req,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 cpu_ack,
    input  logic                 cpu_req,
    input  logic                 cpu_halt,
    input  logic                 cpu_load,
    input  logic                 cpu_store,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    input  logic [WORD_SIZE-1:0] cpu_addr,
    input  logic                 mem_ack,
    output logic                 mem_req,
    output logic                 mem_load,
    output logic                 mem_store,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic                 done
);

    cpu_state_t           state;
    logic                 l_load;
    logic                 l_store;
    logic [WORD_SIZE-1:0] l_addr;
    logic [WORD_SIZE-1:0] l_wdata;
    logic                 eof_seen;

    logic                 in_full, in_empty, in_push, in_pop;
    logic                 out_full, out_empty, out_push;
    logic [WORD_SIZE-1:0] in_head;

    // Input prefetch: request whenever there is room and the stream is not yet exhausted.
    assign in_req  = ~areset & ~in_full & ~eof_seen;
    assign in_push = in_ack & ~in_eof;
    assign in_pop  = (state == S_IORD) & ~in_empty;

    // Output drain: the FIFO head is offered whenever it holds a word.
    assign out_req  = ~out_empty;
    // The push uses the full flag from the start of the cycle, so a same-cycle out_ack cannot free the slot.
    assign out_push = (state == S_IOWR) & ~out_full;

    // The memory port is driven from the latched request while mem_req is held.
    assign mem_load  = mem_req & l_load;
    assign mem_store = mem_req & l_store;
    assign mem_addr  = l_addr;
    assign mem_wdata = l_wdata;

    assign done = ~areset & cpu_halt & (state == S_IDLE) & out_empty;

    subleq_fifo #(.WIDTH(WORD_SIZE), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk   (clk),
        .areset(areset),
        .push  (in_push),
        .pop   (in_pop),
        .wdata (in_data),
        .full  (in_full),
        .empty (in_empty),
        .head  (in_head)
    );

    subleq_fifo #(.WIDTH(WORD_SIZE), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk   (clk),
        .areset(areset),
        .push  (out_push),
        .pop   (out_ack),
        .wdata (l_wdata),
        .full  (out_full),
        .empty (out_empty),
        .head  (out_data)
    );

    // eof is sticky until reset and stops all further input requests.
    always_ff @(posedge clk) begin
        if (areset)                 eof_seen <= 1'b0;
        else if (in_ack && in_eof)  eof_seen <= 1'b1;
    end

    // CPU access FSM; cpu_ack and cpu_rdata are registered and last exactly one cycle in RESP.
    always_ff @(posedge clk) begin
        if (areset) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            l_load    <= 1'b0;
            l_store   <= 1'b0;
            l_addr    <= '0;
            l_wdata   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_req && !cpu_halt) begin
                        l_load  <= cpu_load;
                        l_store <= cpu_store;
                        l_addr  <= cpu_addr;
                        l_wdata <= cpu_wdata;
                        if (cpu_addr != IO_ADDR) begin
                            state   <= S_MEM;
                            mem_req <= 1'b1;
                        end else if (cpu_load) begin
                            state <= S_IORD;
                        end else if (cpu_store) begin
                            state <= S_IOWR;
                        end else begin
                            // An IO access with neither qualifier completes with no side effect.
                            state     <= S_RESP;
                            cpu_ack   <= 1'b1;
                            cpu_rdata <= '0;
                        end
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        cpu_ack   <= 1'b1;
                        cpu_rdata <= l_load ? mem_rdata : '0;
                        state     <= S_RESP;
                    end
                end
                S_IORD: begin
                    if (!in_empty) begin
                        cpu_ack   <= 1'b1;
                        cpu_rdata <= in_head;
                        state     <= S_RESP;
                    end else if (eof_seen) begin
                        cpu_ack   <= 1'b1;
                        cpu_rdata <= '1;
                        state     <= S_RESP;
                    end
                end
                S_IOWR: begin
                    if (!out_full) begin
                        cpu_ack   <= 1'b1;
                        cpu_rdata <= '0;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    cpu_ack   <= 1'b0;
                    cpu_rdata <= '0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_subleq_mmio_fifo.sv
// Scoreboard bench for subleq_mmio_fifo: expected CPU read data and output
// stream words are queued when stimulus is driven and checked when the DUT
// acknowledges or presents them.
module tb_subleq_mmio_fifo;

    localparam int         W  = 16;
    localparam logic [W-1:0] IO = 16'hFFFF;

    logic         clk = 1'b0;
    logic         areset;
    logic         in_eof, in_ack, in_req;
    logic [W-1:0] in_data;
    logic         out_ack, out_req;
    logic [W-1:0] out_data;
    logic         cpu_ack, cpu_req, cpu_halt, cpu_load, cpu_store;
    logic [W-1:0] cpu_rdata, cpu_wdata, cpu_addr;
    logic         mem_ack, mem_req, mem_load, mem_store;
    logic [W-1:0] mem_rdata, mem_wdata, mem_addr;
    logic         done;

    logic [W-1:0] exp_rd[$];
    logic [W-1:0] exp_out[$];
    int           vec_cnt = 0;
    int           err_cnt = 0;
    int           n;
    int           mcnt;

    subleq_mmio_fifo dut (
        .clk(clk), .areset(areset),
        .in_eof(in_eof), .in_ack(in_ack), .in_req(in_req), .in_data(in_data),
        .out_ack(out_ack), .out_req(out_req), .out_data(out_data),
        .cpu_ack(cpu_ack), .cpu_req(cpu_req), .cpu_halt(cpu_halt),
        .cpu_load(cpu_load), .cpu_store(cpu_store), .cpu_rdata(cpu_rdata),
        .cpu_wdata(cpu_wdata), .cpu_addr(cpu_addr),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_load(mem_load),
        .mem_store(mem_store), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
        .mem_addr(mem_addr), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock step; acks are one-cycle pulses, so they drop after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        in_ack  = 1'b0;
        in_eof  = 1'b0;
        out_ack = 1'b0;
        mem_ack = 1'b0;
    endtask

    task automatic cpu_drive(input logic ld, input logic st, input logic [W-1:0] a,
                             input logic [W-1:0] wd);
        cpu_req   = 1'b1;
        cpu_load  = ld;
        cpu_store = st;
        cpu_addr  = a;
        cpu_wdata = wd;
    endtask

    // Wait for cpu_ack and compare rdata with the scoreboard head; nd is cycles to ack.
    task automatic wait_ack(input string tag, input int budget, output int nd);
        logic [W-1:0] e;
        nd = 0;
        while (nd < budget && cpu_ack !== 1'b1) begin
            tick();
            nd++;
        end
        if (cpu_ack !== 1'b1) begin
            chk({tag, "_timeout"}, 32'(cpu_ack), 32'd1);
        end else begin
            e = (exp_rd.size() != 0) ? exp_rd.pop_front() : 16'hDEAD;
            chk(tag, 32'(cpu_rdata), 32'(e));
            tick();
            chk({tag, "_ack_once"}, 32'(cpu_ack), 32'd0);
        end
        cpu_req   = 1'b0;
        cpu_load  = 1'b0;
        cpu_store = 1'b0;
    endtask

    // Check the offered output word against the scoreboard and accept it.
    task automatic pulse_out_ack(input string tag);
        logic [W-1:0] e;
        e = (exp_out.size() != 0) ? exp_out.pop_front() : 16'hDEAD;
        chk({tag, "_req"}, 32'(out_req), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(e));
        out_ack = 1'b1;
    endtask

    task automatic io_store(input logic [W-1:0] v);
        exp_rd.push_back('0);
        exp_out.push_back(v);
        cpu_drive(1'b0, 1'b1, IO, v);
        wait_ack("io_store", 10, n);
        chk("io_store_lat", 32'(n), 32'd2);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        cpu_req = 1'b0; cpu_load = 1'b0; cpu_store = 1'b0; cpu_halt = 1'b0;
        in_ack = 1'b0; in_eof = 1'b0; out_ack = 1'b0; mem_ack = 1'b0;
        tick();
        tick();
        areset = 1'b0;
        exp_rd.delete();
        exp_out.delete();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1;
        in_eof = 0; in_ack = 0; in_data = '0; out_ack = 0;
        cpu_req = 0; cpu_halt = 0; cpu_load = 0; cpu_store = 0;
        cpu_wdata = '0; cpu_addr = '0; mem_ack = 0; mem_rdata = '0;

        // Reset state
        tick();
        tick();
        chk("rst_in_req", 32'(in_req), 32'd0);
        chk("rst_out_req", 32'(out_req), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_ls", 32'({mem_load, mem_store}), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        areset = 1'b0;
        tick();
        chk("in_req_after_rst", 32'(in_req), 32'd1);

        // IO load on an empty FIFO waits; a word pushed in cycle N pops in N+1
        exp_rd.push_back(16'h0099);
        cpu_drive(1'b1, 1'b0, IO, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("iord_wait", 32'(cpu_ack), 32'd0);
        end
        in_data = 16'h0099;
        in_ack  = 1'b1;
        wait_ack("nobypass", 10, n);
        chk("nobypass_lat", 32'(n), 32'd2);

        // Input stream 5, 7, eof; reads return 5, 7, then all-ones
        do_reset();
        in_data = 16'h0005; in_ack = 1'b1; tick();
        in_data = 16'h0007; in_ack = 1'b1; tick();
        chk("in_req_pre_eof", 32'(in_req), 32'd1);
        in_eof = 1'b1; in_ack = 1'b1; tick();
        chk("in_req_post_eof", 32'(in_req), 32'd0);
        begin
            logic [W-1:0] vals [3];
            vals[0] = 16'h0005; vals[1] = 16'h0007; vals[2] = 16'hFFFF;
            for (int i = 0; i < 3; i++) begin
                exp_rd.push_back(vals[i]);
                cpu_drive(1'b1, 1'b0, IO, '0);
                wait_ack("io_load", 10, n);
                chk("io_load_lat", 32'(n), 32'd2);
            end
        end
        chk("in_req_stays_low", 32'(in_req), 32'd0);

        // Five stores with no drain: four fit, the fifth waits for a pop
        do_reset();
        for (int v = 1; v <= 4; v++) io_store(W'(v));
        exp_rd.push_back('0);
        exp_out.push_back(16'd5);
        cpu_drive(1'b0, 1'b1, IO, 16'd5);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("iowr_full_wait", 32'(cpu_ack), 32'd0);
        end
        // Pop in the same cycle the fifth store sees a full FIFO: push lands one cycle later
        pulse_out_ack("drain1");
        wait_ack("store5", 10, n);
        chk("store5_deferred_lat", 32'(n), 32'd2);
        for (int i = 0; i < 4; i++) begin
            pulse_out_ack("drain");
            tick();
        end
        chk("out_empty_after_drain", 32'(out_req), 32'd0);

        // Memory load, ack after three request cycles
        exp_rd.push_back(16'h1234);
        cpu_drive(1'b1, 1'b0, 16'h0010, '0);
        mcnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_req) mcnt++;
        end
        chk("mem_req_cycles", 32'(mcnt), 32'd3);
        chk("mem_addr", 32'(mem_addr), 32'h0010);
        chk("mem_load", 32'({mem_load, mem_store}), 32'b10);
        chk("mem_no_early_ack", 32'(cpu_ack), 32'd0);
        mem_rdata = 16'h1234;
        mem_ack   = 1'b1;
        wait_ack("mem_load_data", 10, n);
        chk("mem_ack_lat", 32'(n), 32'd1);
        chk("mem_req_dropped", 32'(mem_req), 32'd0);

        // Memory store returns zero read data
        exp_rd.push_back('0);
        cpu_drive(1'b0, 1'b1, 16'h0030, 16'hBEEF);
        tick();
        chk("mst_ls", 32'({mem_req, mem_load, mem_store}), 32'b101);
        chk("mst_wdata", 32'(mem_wdata), 32'hBEEF);
        mem_rdata = 16'h5555;
        mem_ack   = 1'b1;
        wait_ack("mem_store_rdata", 10, n);

        // Address one below IO_ADDR goes to memory
        exp_rd.push_back(16'h4242);
        cpu_drive(1'b1, 1'b0, 16'hFFFE, '0);
        tick();
        chk("fffe_to_mem", 32'(mem_req), 32'd1);
        mem_rdata = 16'h4242;
        mem_ack   = 1'b1;
        wait_ack("fffe_data", 10, n);

        // Reset during memory wait abandons the access
        io_store(16'h0077);
        chk("pre_rst_out_req", 32'(out_req), 32'd1);
        cpu_drive(1'b1, 1'b0, 16'h0020, '0);
        tick();
        tick();
        chk("mid_mem_req", 32'(mem_req), 32'd1);
        areset = 1'b1;
        tick();
        chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_mid_out_req", 32'(out_req), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        areset = 1'b0;
        cpu_req = 1'b0; cpu_load = 1'b0;
        exp_out.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_stale_ack", 32'({cpu_ack, mem_req}), 32'd0);
        end

        // Halt with two words queued: done rises only once both are drained
        do_reset();
        io_store(16'h000A);
        io_store(16'h000B);
        cpu_halt = 1'b1;
        tick();
        chk("halt_done_busy", 32'(done), 32'd0);
        cpu_drive(1'b0, 1'b1, IO, 16'h000C);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_ignores_req", 32'({cpu_ack, done}), 32'd0);
        end
        pulse_out_ack("halt_drain_a");
        tick();
        chk("halt_done_one_left", 32'(done), 32'd0);
        pulse_out_ack("halt_drain_b");
        tick();
        chk("halt_done", 32'(done), 32'd1);
        chk("halt_out_empty", 32'(out_req), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("halt_still_idle", 32'({cpu_ack, done}), 32'b01);
        end
        cpu_req = 1'b0; cpu_store = 1'b0; cpu_halt = 1'b0;
        tick();
        chk("unhalt_done", 32'(done), 32'd0);

        chk("scoreboard_empty", 32'(exp_rd.size() + exp_out.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
